// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: counter encodings and FSM states.
package bpu_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef logic [1:0] bpu_state_t;

    localparam bpu_state_t ST_INIT  = 2'd0;
    localparam bpu_state_t ST_RUN   = 2'd1;
    localparam bpu_state_t ST_CLEAR = 2'd2;

    localparam int STAT_W = 32;

endpackage

// File: rtl/bpu_sat_ctr.sv
// Next value of a 2-bit saturating direction counter (0..3).
module bpu_sat_ctr
    import bpu_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: IF lookup, EX resolve/update, registered redirect.
// Optional BPU_STATS_EN adds branch and mispredict counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter  int PC_W    = 9,
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_target,
    input  logic            flush_all,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
`ifdef BPU_STATS_EN
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts,
`endif
    output logic            bpu_ready
);

    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       ctr;
    } entry_t;

    logic [ENTRIES-1:0] r_valid;
    entry_t             r_data [ENTRIES];
    bpu_state_t         r_state;
    logic [IDX_W-1:0]   r_walk_idx;
    logic               r_redirect;
    logic [PC_W-1:0]    r_redirect_pc;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    entry_t           w_ex_entry;
    logic             w_ex_hit;
    logic             w_ctl;
    logic             w_tk;
    logic             w_mispred;
    logic             w_upd;
    logic [1:0]       w_ctr_next;
    logic             w_wr_en;
    logic             w_set_valid;
    logic             w_clr_valid;
    entry_t           w_wr_data;
    logic             w_unused;

    assign w_unused = ^if_pc[1:0];

    // Lookup reads the registered table only, so an entry updated this cycle shows old contents.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_if_tag    = if_pc[PC_W-1:IDX_W+2];
    assign w_if_hit    = r_valid[w_if_idx] && (r_data[w_if_idx].tag == w_if_tag);
    assign pred_taken  = (r_state == ST_RUN) && w_if_hit && r_data[w_if_idx].ctr[1];
    assign pred_target = w_if_hit ? r_data[w_if_idx].target : '0;

    assign w_ex_idx   = ex_pc[IDX_W+1:2];
    assign w_ex_tag   = ex_pc[PC_W-1:IDX_W+2];
    assign w_ex_entry = r_data[w_ex_idx];
    assign w_ex_hit   = r_valid[w_ex_idx] && (w_ex_entry.tag == w_ex_tag);

    assign w_ctl     = ex_is_branch | ex_is_jump;
    assign w_tk      = ex_is_jump | ex_taken;
    assign w_mispred = ex_valid && (w_ctl ? ((w_tk != ex_pred_taken) ||
                                             (w_tk && (ex_target != ex_pred_target)))
                                          : ex_pred_taken);
    assign w_upd     = ex_valid && (r_state == ST_RUN) && !flush_all;

    bpu_sat_ctr u_sat_ctr (
        .i_ctr (w_ex_entry.ctr),
        .i_inc (ex_taken),
        .o_ctr (w_ctr_next)
    );

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_wr_en     = 1'b0;
        w_set_valid = 1'b0;
        w_clr_valid = 1'b0;
        w_wr_data   = w_ex_entry;
        if (w_upd) begin
            if (ex_is_jump) begin
                w_wr_en     = 1'b1;
                w_set_valid = 1'b1;
                w_wr_data   = '{tag: w_ex_tag, target: ex_target, ctr: CTR_ST};
            end else if (ex_is_branch) begin
                if (w_ex_hit) begin
                    w_wr_en       = 1'b1;
                    w_wr_data.ctr = w_ctr_next;
                    if (ex_taken) w_wr_data.target = ex_target;
                end else if (ex_taken) begin
                    w_wr_en     = 1'b1;
                    w_set_valid = 1'b1;
                    w_wr_data   = '{tag: w_ex_tag, target: ex_target, ctr: CTR_WT};
                end
            end else if (w_ex_hit) begin
                w_clr_valid = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_state    <= ST_INIT;
            r_walk_idx <= '0;
        end else if (r_state == ST_RUN) begin
            if (flush_all) begin
                r_state    <= ST_CLEAR;
                r_walk_idx <= '0;
            end else if (w_set_valid) begin
                r_valid[w_ex_idx] <= 1'b1;
            end else if (w_clr_valid) begin
                r_valid[w_ex_idx] <= 1'b0;
            end
        end else begin
            r_valid[r_walk_idx] <= 1'b0;
            if (flush_all) begin
                r_state    <= ST_CLEAR;
                r_walk_idx <= '0;
            end else if (r_walk_idx == IDX_W'(ENTRIES - 1)) begin
                r_state    <= ST_RUN;
                r_walk_idx <= '0;
            end else begin
                r_walk_idx <= r_walk_idx + IDX_W'(1);
            end
        end
    end

    // NOTE: payload fields have no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_data[w_ex_idx] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_mispred;
            if (w_mispred) r_redirect_pc <= w_tk ? ex_target : ex_pc + PC_W'(4);
        end
    end

    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign bpu_ready   = (r_state == ST_RUN);

`ifdef BPU_STATS_EN
    logic [STAT_W-1:0] r_stat_branches;
    logic [STAT_W-1:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (ex_valid && w_ctl) r_stat_branches <= r_stat_branches + STAT_W'(1);
            if (w_mispred)         r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table plus reset/flush sequences.
// Checks the stat counters too when BPU_STATS_EN is defined.
module tb_branch_predict_unit;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;
    logic            flush_all;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            bpu_ready;
`ifdef BPU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    branch_predict_unit #(.PC_W(PC_W), .ENTRIES(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush_all      (flush_all),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
`ifdef BPU_STATS_EN
        .stat_branches  (stat_branches),
        .stat_mispredicts(stat_mispredicts),
`endif
        .bpu_ready      (bpu_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic            br;
        logic            jmp;
        logic            tk;
        logic            ptk;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] tgt;
        logic [PC_W-1:0] ptgt;
        logic [PC_W-1:0] ifpc;
        logic            e_redir;
        logic [PC_W-1:0] e_rpc;
        logic            e_ptk;
        logic [PC_W-1:0] e_ptgt;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic v, input logic br, input logic jmp, input logic tk,
                                input logic ptk, input logic [PC_W-1:0] pc,
                                input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] ptgt,
                                input logic [PC_W-1:0] ifpc, input logic e_redir,
                                input logic [PC_W-1:0] e_rpc, input logic e_ptk,
                                input logic [PC_W-1:0] e_ptgt);
        vec_t r;
        r.v = v; r.br = br; r.jmp = jmp; r.tk = tk; r.ptk = ptk;
        r.pc = pc; r.tgt = tgt; r.ptgt = ptgt; r.ifpc = ifpc;
        r.e_redir = e_redir; r.e_rpc = e_rpc; r.e_ptk = e_ptk; r.e_ptgt = e_ptgt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic jmp, input logic tk,
                            input logic ptk, input logic [PC_W-1:0] pc,
                            input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] ptgt);
        ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
        ex_pred_taken = ptk; ex_pc = pc; ex_target = tgt; ex_pred_target = ptgt;
    endtask

    // Advance one clock and count what the stat counters should have seen.
    task automatic tick(input logic mp);
        if (ex_valid && (ex_is_branch || ex_is_jump)) exp_br++;
        if (mp) exp_mp++;
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BPU_STATS_EN
        check({tag, "_stat_branches"}, stat_branches, exp_br);
        check({tag, "_stat_mispredicts"}, stat_mispredicts, exp_mp);
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    initial begin
        //            v  br j  tk ptk pc      tgt     ptgt    if_pc   redir rpc    ptk pred_tgt
        vecs[0]  = mk(1, 1, 0, 1, 0, 9'h020, 9'h040, 9'h000, 9'h020, 1, 9'h040, 1, 9'h040);
        vecs[1]  = mk(1, 1, 0, 0, 1, 9'h020, 9'h000, 9'h040, 9'h020, 1, 9'h024, 0, 9'h040);
        vecs[2]  = mk(1, 1, 0, 0, 0, 9'h020, 9'h000, 9'h000, 9'h020, 0, 9'h000, 0, 9'h040);
        vecs[3]  = mk(1, 1, 0, 0, 1, 9'h1FC, 9'h000, 9'h000, 9'h1FC, 1, 9'h000, 0, 9'h000);
        vecs[4]  = mk(1, 1, 0, 1, 1, 9'h020, 9'h040, 9'h040, 9'h020, 0, 9'h000, 0, 9'h040);
        vecs[5]  = mk(1, 1, 0, 1, 1, 9'h020, 9'h040, 9'h040, 9'h020, 0, 9'h000, 1, 9'h040);
        vecs[6]  = mk(1, 1, 0, 1, 1, 9'h020, 9'h080, 9'h040, 9'h020, 1, 9'h080, 1, 9'h080);
        vecs[7]  = mk(1, 1, 0, 1, 1, 9'h020, 9'h080, 9'h080, 9'h020, 0, 9'h000, 1, 9'h080);
        vecs[8]  = mk(1, 1, 0, 0, 1, 9'h020, 9'h000, 9'h080, 9'h020, 1, 9'h024, 1, 9'h080);
        vecs[9]  = mk(1, 0, 1, 0, 0, 9'h010, 9'h100, 9'h000, 9'h010, 1, 9'h100, 1, 9'h100);
        vecs[10] = mk(1, 0, 0, 0, 0, 9'h010, 9'h000, 9'h000, 9'h010, 0, 9'h000, 0, 9'h000);
        vecs[11] = mk(1, 0, 0, 0, 1, 9'h030, 9'h000, 9'h000, 9'h030, 1, 9'h034, 0, 9'h000);
        vecs[12] = mk(0, 1, 0, 1, 0, 9'h050, 9'h060, 9'h000, 9'h050, 0, 9'h000, 0, 9'h000);
        vecs[13] = mk(0, 0, 0, 0, 0, 9'h000, 9'h000, 9'h000, 9'h0A0, 0, 9'h000, 0, 9'h000);
        vecs[14] = mk(1, 0, 1, 0, 0, 9'h010, 9'h100, 9'h000, 9'h010, 1, 9'h100, 1, 9'h100);

        rst_n = 1'b0;
        flush_all = 1'b0;
        if_pc = 9'h020;
        drive_ex(0, 0, 0, 0, 0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_redirect_pc", {23'd0, redirect_pc}, 32'd0);
        check("rst_ready", {31'd0, bpu_ready}, 32'd0);

        // Release, then reset again mid-walk: the walk must restart from index 0.
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1 check("midwalk_rst_ready", {31'd0, bpu_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("init%0d_ready", i), {31'd0, bpu_ready}, 32'd0);
            check($sformatf("init%0d_pred", i), {31'd0, pred_taken}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("init_done_ready", {31'd0, bpu_ready}, 32'd1);
        check_stats("post_init");

        for (int i = 0; i < 15; i++) begin
            if_pc = vecs[i].ifpc;
            drive_ex(vecs[i].v, vecs[i].br, vecs[i].jmp, vecs[i].tk, vecs[i].ptk,
                     vecs[i].pc, vecs[i].tgt, vecs[i].ptgt);
            tick(vecs[i].e_redir);
            check($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
            if (vecs[i].e_redir)
                check($sformatf("v%0d_redirect_pc", i), {23'd0, redirect_pc}, {23'd0, vecs[i].e_rpc});
            check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_ptk});
            check($sformatf("v%0d_pred_target", i), {23'd0, pred_target}, {23'd0, vecs[i].e_ptgt});
        end

        // Flush together with an allocating update: the flush wins, the redirect still fires.
        if_pc = 9'h010;
        flush_all = 1'b1;
        drive_ex(1, 1, 0, 1, 0, 9'h070, 9'h090, 9'h000);
        tick(1'b1);
        check("flush_redirect", {31'd0, redirect}, 32'd1);
        check("flush_redirect_pc", {23'd0, redirect_pc}, 32'h090);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clr%0d_ready", i), {31'd0, bpu_ready}, 32'd0);
            check($sformatf("clr%0d_pred", i), {31'd0, pred_taken}, 32'd0);
            drive_ex(1, 0, 1, 0, 0, 9'h010, 9'h100, 9'h000);
            tick(1'b1);
            check($sformatf("clr%0d_redirect", i), {31'd0, redirect}, 32'd1);
        end
        check("clr_done_ready", {31'd0, bpu_ready}, 32'd1);
        #1 check("clr_lookup_010_pred", {31'd0, pred_taken}, 32'd0);
        check("clr_lookup_010_tgt", {23'd0, pred_target}, 32'd0);
        if_pc = 9'h070;
        #1 check("clr_lookup_070_tgt", {23'd0, pred_target}, 32'd0);
        check_stats("pre_flush2");

        // Second flush in the middle of a walk restarts it.
        flush_all = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rw%0d_ready", i), {31'd0, bpu_ready}, 32'd0);
            if (i == 4) flush_all = 1'b1;
            tick(1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rs%0d_ready", i), {31'd0, bpu_ready}, 32'd0);
            tick(1'b0);
        end
        check("restart_done_ready", {31'd0, bpu_ready}, 32'd1);
        check("restart_redirect", {31'd0, redirect}, 32'd0);
        check_stats("post_flush2");

        $display("Model totals: %0d branches, %0d mispredicts", exp_br, exp_mp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
